// File: rtl/tdm_pkg.sv
// tdm_pkg: slot indices, frame size and FSM state encoding for the TDM demultiplexer.
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
endpackage

// File: rtl/tdm_demux_4to1.sv
// tdm_demux_4to1: reassembles serial A,B,C,D beats into a parallel frame with
// first-slot alignment, sync-error detection and valid/ready on both sides.
module tdm_demux_4to1
  import tdm_pkg::*;
#(
  parameter int DATA_WIDTH = 2
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [DATA_WIDTH-1:0] In_data,
  input  logic                  In_valid,
  input  logic                  In_first,
  output logic                  In_ready,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] C,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [1:0]            Slot,
  output logic                  Sync_error
);
  logic [0:0] state;
  logic [DATA_WIDTH-1:0] s0, s1, s2;
  logic acc;
  // Only the completing beat stalls, and only while an unconsumed frame occupies A..D.
  assign In_ready = !(Slot == SLOT_D && Out_valid && !Out_ready);
  assign acc = In_valid && In_ready;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= HUNT;
      Slot <= SLOT_A;
      Sync_error <= 1'b0;
      Out_valid <= 1'b0;
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      A <= '0;
      B <= '0;
      C <= '0;
      D <= '0;
    end else begin
      Sync_error <= 1'b0;
      if (Out_valid && Out_ready) Out_valid <= 1'b0;
      if (acc) begin
        if (In_first) begin
          s0 <= In_data;
          Slot <= SLOT_B;
          state <= COLLECT;
          Sync_error <= state == COLLECT && Slot != SLOT_A;
        end else if (state == COLLECT) begin
          if (Slot == SLOT_A) begin
            Sync_error <= 1'b1;
            state <= HUNT;
          end else if (Slot == SLOT_D) begin
            A <= s0;
            B <= s1;
            C <= s2;
            D <= In_data;
            Out_valid <= 1'b1;
            Slot <= SLOT_A;
          end else begin
            if (Slot == SLOT_B) s1 <= In_data;
            else s2 <= In_data;
            Slot <= Slot + 2'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_4to1.sv
// tb_tdm_demux_4to1: directed vectors with hand-computed frames for the TDM demultiplexer.
module tb_tdm_demux_4to1;
  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] In_data = '0;
  logic       In_valid = 1'b0;
  logic       In_first = 1'b0;
  logic       In_ready;
  logic [1:0] A, B, C, D;
  logic       Out_valid;
  logic       Out_ready = 1'b0;
  logic [1:0] Slot;
  logic       Sync_error;
  int checks = 0;
  int errors = 0;

  tdm_demux_4to1 #(.DATA_WIDTH(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .In_data(In_data), .In_valid(In_valid),
    .In_first(In_first), .In_ready(In_ready), .A(A), .B(B), .C(C), .D(D),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Slot(Slot), .Sync_error(Sync_error)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives one beat for one clock edge; returns at the following negedge.
  task automatic send(input logic [1:0] d, input logic f);
    In_valid = 1'b1;
    In_data = d;
    In_first = f;
    @(negedge Clock);
    In_valid = 1'b0;
    In_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic frame_is(input string tag, input int a, input int b, input int c, input int d);
    check({tag, " valid"}, Out_valid, 1);
    check({tag, " A"}, A, a);
    check({tag, " B"}, B, b);
    check({tag, " C"}, C, c);
    check({tag, " D"}, D, d);
  endtask

  initial begin
    idle(2);
    check("rst valid", Out_valid, 0);
    check("rst slot", Slot, 0);
    check("rst sync", Sync_error, 0);
    check("rst ready", In_ready, 1);
    check("rst A", A, 0);
    Reset_n = 1'b1;
    idle(1);

    // clean frame, consumer ready
    Out_ready = 1'b1;
    send(2'b00, 1); check("s2 slot1", Slot, 1);
    send(2'b01, 0); check("s2 slot2", Slot, 2);
    send(2'b10, 0); check("s2 slot3", Slot, 3);
    send(2'b11, 0);
    frame_is("s2", 0, 1, 2, 3);
    check("s2 sync", Sync_error, 0);
    check("s2 slot wrap", Slot, 0);
    idle(1);
    check("s2 valid one cycle", Out_valid, 0);

    // reset mid-frame clears outputs and the partial frame
    send(2'b10, 1);
    send(2'b01, 0);
    Reset_n = 1'b0;
    #1;
    check("s1 A", A, 0);
    check("s1 D", D, 0);
    check("s1 slot", Slot, 0);
    check("s1 valid", Out_valid, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    send(2'b00, 1); send(2'b01, 0); send(2'b10, 0); send(2'b11, 0);
    frame_is("s1 after", 0, 1, 2, 3);
    idle(1);

    // back-to-back frames with a stalled consumer
    Out_ready = 1'b0;
    send(2'b00, 1); send(2'b01, 0); send(2'b10, 0); send(2'b11, 0);
    frame_is("s3 f1", 0, 1, 2, 3);
    send(2'b11, 1); send(2'b10, 0); send(2'b01, 0);
    check("s3 slot", Slot, 3);
    check("s3 stall", In_ready, 0);
    send(2'b00, 0);
    check("s3 still stalled", In_ready, 0);
    frame_is("s3 held", 0, 1, 2, 3);
    check("s3 slot held", Slot, 3);
    In_valid = 1'b1;
    In_data = 2'b00;
    Out_ready = 1'b1;
    #1 check("s3 ready released", In_ready, 1);
    @(negedge Clock);
    In_valid = 1'b0;
    frame_is("s3 f2", 3, 2, 1, 0);
    idle(1);
    check("s3 drained", Out_valid, 0);

    // early In_first at Slot=2
    send(2'b00, 1); send(2'b01, 0);
    send(2'b01, 1);
    check("s4 sync", Sync_error, 1);
    check("s4 slot", Slot, 1);
    check("s4 no valid", Out_valid, 0);
    send(2'b10, 0);
    check("s4 sync pulse", Sync_error, 0);
    send(2'b11, 0);
    check("s4 no valid2", Out_valid, 0);
    send(2'b00, 0);
    frame_is("s4", 1, 2, 3, 0);
    idle(1);

    // hunting after reset: unmarked beats ignored
    Reset_n = 1'b0;
    idle(1);
    Reset_n = 1'b1;
    send(2'b11, 0); send(2'b10, 0); send(2'b01, 0);
    check("s5 valid", Out_valid, 0);
    check("s5 sync", Sync_error, 0);
    check("s5 slot", Slot, 0);
    send(2'b10, 1); send(2'b11, 0); send(2'b00, 0); send(2'b01, 0);
    frame_is("s5", 2, 3, 0, 1);
    idle(1);

    // gaps inside a frame, then a missing marker
    send(2'b00, 1); idle(2);
    send(2'b01, 0); idle(3);
    check("s6 slot in gap", Slot, 2);
    send(2'b10, 0); idle(1);
    send(2'b11, 0);
    frame_is("s6", 0, 1, 2, 3);
    send(2'b01, 0);
    check("s6 sync", Sync_error, 1);
    check("s6 slot", Slot, 0);
    send(2'b10, 0);
    check("s6 hunt no sync", Sync_error, 0);
    check("s6 hunt slot", Slot, 0);
    send(2'b11, 1); send(2'b00, 0); send(2'b01, 0); send(2'b10, 0);
    frame_is("s6 resync", 3, 0, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
